// File: rtl/div_pkg.sv
// Shared types and helpers for the Goldschmidt divide sequencer and its rounding blocks.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_WAIT,
        S_REM_SUB,
        S_ROUND,
        S_DONE
    } div_state_t;

    typedef enum logic {
        RM_NE = 1'b0,
        RM_Z  = 1'b1
    } round_mode_t;

    // Number of fraction bits for a [1,2)-normalized fixed-point operand.
    function automatic int unsigned FRAC(input int unsigned width);
        return width - 2;
    endfunction

endpackage

// File: rtl/round_ne.sv
// Round-to-nearest at the ULP position: bump up when past the midpoint, ties truncate.
module round_ne #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned ULP   = 4
) (
    input  logic [WIDTH-1:0] i_n,
    input  logic             i_rem_pos,
    output logic [WIDTH-1:0] o_q
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1) << ULP;
    localparam logic [WIDTH-1:0] MASK = ~(STEP - WIDTH'(1));

    logic [WIDTH-1:0] w_trunc;

    always_comb begin
        w_trunc = i_n & MASK;
        o_q     = (i_n[ULP-1] && i_rem_pos) ? w_trunc + STEP : w_trunc;
    end

endmodule

// File: rtl/round_z.sv
// Round-toward-zero at the ULP position: step down when the truncation overshoots the quotient.
module round_z #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned ULP   = 4
) (
    input  logic [WIDTH-1:0] i_n,
    input  logic             i_rem_neg,
    output logic [WIDTH-1:0] o_q
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1) << ULP;
    localparam logic [WIDTH-1:0] MASK = ~(STEP - WIDTH'(1));

    logic [WIDTH-1:0] w_trunc;

    always_comb begin
        w_trunc = i_n & MASK;
        o_q     = (!i_n[ULP-1] && i_rem_neg) ? w_trunc - STEP : w_trunc;
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Goldschmidt quotient sequencer: drives a shared external multiplier through the
// N/D iterations and a remainder multiply, then rounds and hands back the quotient.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH   = 28,
    parameter int unsigned ULP     = 4,
    parameter int unsigned ITERS   = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   q,
    output logic               dz
);

    localparam int unsigned FB = FRAC(WIDTH);
    localparam int unsigned RW = 2*WIDTH + 1;
    localparam int unsigned SW = $clog2(2*ITERS + 2);
    localparam int unsigned CW = $clog2(MUL_LAT) + 1;

    localparam logic [SW-1:0]    LAST_STEP = SW'(2*ITERS);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(MUL_LAT - 1);
    localparam logic [WIDTH-1:0] TWO       = WIDTH'(2) << FB;
    localparam logic [WIDTH-1:0] R_MASK    = ~((WIDTH'(1) << (ULP-1)) - WIDTH'(1));
    localparam logic [WIDTH-1:0] Q_DZ      = ~((WIDTH'(1) << ULP) - WIDTH'(1));

    div_state_t          r_state, w_next;
    round_mode_t         r_mode;
    logic [WIDTH-1:0]    r_a, r_b, r_n, r_d, r_k, r_q;
    logic [2*WIDTH-1:0]  r_p;
    logic [SW-1:0]       r_step;
    logic [CW-1:0]       r_cnt;
    logic                r_dz, r_rem_neg, r_rem_pos;

    logic [WIDTH-1:0]    w_k, w_r, w_prod, w_q_ne, w_q_z;
    logic [RW-1:0]       w_rem;
    logic                w_even, w_rem_step, w_capture;

    assign w_k        = TWO - r_d;
    assign w_r        = r_n & R_MASK;
    assign w_prod     = mul_p[FB+WIDTH-1:FB];
    assign w_rem      = (RW'(r_a) << FB) - RW'(r_p);
    assign w_even     = ~r_step[0];
    assign w_rem_step = (r_step == LAST_STEP);
    assign w_capture  = (r_state == S_WAIT) && (r_cnt == CNT_LAST);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign mul_start = (r_state == S_MUL);
    assign q         = r_q;
    assign dz        = r_dz;

    round_ne #(.WIDTH(WIDTH), .ULP(ULP)) u_round_ne (
        .i_n       (r_n),
        .i_rem_pos (r_rem_pos),
        .o_q       (w_q_ne)
    );

    round_z #(.WIDTH(WIDTH), .ULP(ULP)) u_round_z (
        .i_n       (r_n),
        .i_rem_neg (r_rem_neg),
        .o_q       (w_q_z)
    );

    // Odd steps use the K latched before D was overwritten by the even step.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        if (r_state == S_MUL || r_state == S_WAIT) begin
            if (w_rem_step) begin
                mul_x = w_r;
                mul_y = r_b;
            end else if (w_even) begin
                mul_x = r_d;
                mul_y = w_k;
            end else begin
                mul_x = r_n;
                mul_y = r_k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Divide-by-zero passes through ROUND so out_valid still lands one cycle after accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (in_valid) w_next = (b == '0) ? S_ROUND : S_MUL;
            S_MUL:     w_next = S_WAIT;
            S_WAIT:    if (w_capture) w_next = w_rem_step ? S_REM_SUB : S_MUL;
            S_REM_SUB: w_next = S_ROUND;
            S_ROUND:   w_next = S_DONE;
            S_DONE:    if (out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode    <= RM_NE;
            r_a       <= '0;
            r_b       <= '0;
            r_n       <= '0;
            r_d       <= '0;
            r_k       <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_step    <= '0;
            r_cnt     <= '0;
            r_dz      <= 1'b0;
            r_rem_neg <= 1'b0;
            r_rem_pos <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a    <= a;
                    r_b    <= b;
                    r_mode <= round_mode_t'(mode);
                    r_n    <= a;
                    r_d    <= b;
                    r_step <= '0;
                    r_dz   <= (b == '0);
                end
                S_MUL: begin
                    r_cnt <= '0;
                    if (!w_rem_step && w_even) r_k <= w_k;
                end
                S_WAIT: begin
                    if (w_capture) begin
                        r_step <= r_step + SW'(1);
                        if (w_rem_step)  r_p <= mul_p;
                        else if (w_even) r_d <= w_prod;
                        else             r_n <= w_prod;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_REM_SUB: begin
                    r_rem_neg <= w_rem[RW-1];
                    r_rem_pos <= !w_rem[RW-1] && (w_rem != '0);
                end
                S_ROUND: r_q <= r_dz ? Q_DZ : ((r_mode == RM_NE) ? w_q_ne : w_q_z);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a 2-cycle multiplier model that emits junk off its valid cycle.
module tb_div_seq_ctrl;

    localparam int W = 28;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  bv = '0;
    logic          mode = 1'b0;
    logic          mul_start;
    logic [W-1:0]  mul_x, mul_y;
    logic [2*W-1:0] mul_p = '0;
    logic [2*W-1:0] pipe1 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  q;
    logic          dz;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pipe1 <= mul_start ? (2*W)'(mul_x) * (2*W)'(mul_y) : (2*W)'({$urandom, $urandom});
        mul_p <= pipe1;
    end

    div_seq_ctrl #(.WIDTH(28), .ULP(4), .ITERS(4), .MUL_LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (bv),
        .mode      (mode),
        .mul_start (mul_start),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .dz        (dz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_q(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mm);
        logic [W-1:0]   n, d, k, r, t;
        logic [2*W-1:0] pr;
        logic [2*W:0]   rem;
        logic           neg, pos;
        if (mb == '0) return 28'hFFFFFF0;
        n = ma;
        d = mb;
        for (int s = 0; s < 4; s++) begin
            k  = 28'h8000000 - d;
            pr = 56'(d) * 56'(k);
            d  = pr[53:26];
            pr = 56'(n) * 56'(k);
            n  = pr[53:26];
        end
        r   = {n[27:3], 3'b000};
        pr  = 56'(r) * 56'(mb);
        rem = {3'b000, ma, 26'd0} - {1'b0, pr};
        neg = rem[56];
        pos = !neg && (rem != '0);
        t   = {n[27:4], 4'h0};
        if (!mm) return (n[3] && pos) ? t + 28'h10 : t;
        return (!n[3] && neg) ? t - 28'h10 : t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        check({tag, "_dz"},        64'(dz),        64'd0);
        check({tag, "_q"},         64'(q),         64'd0);
        check({tag, "_mul_x"},     64'(mul_x),     64'd0);
        check({tag, "_mul_y"},     64'(mul_y),     64'd0);
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tm);
        logic ok;
        ok = 1'b0;
        a = ta; bv = tbv; mode = tm; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("accept", 64'(ok), 64'd1);
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_req(input string tag, input logic [W-1:0] exp_q, input logic exp_dz,
                              input int exp_lat, input int exp_starts, input logic rel);
        int starts, last, gap_bad, lat;
        starts = 0; last = 0; gap_bad = 0; lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin lat = cyc - acc_cyc; break; end
            if (mul_start) begin
                if (starts > 0 && (cyc - last) != 3) gap_bad++;
                last = cyc;
                starts++;
            end
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_starts"},  64'(starts), 64'(exp_starts));
        check({tag, "_spacing"}, 64'(gap_bad), 64'd0);
        check({tag, "_q"},       64'(q), 64'(exp_q));
        check({tag, "_dz"},      64'(dz), 64'(exp_dz));
        if (rel) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0]   held_q, ra, rb;
        logic [2*W-1:0] lhs, rhs;
        int             bad;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        send(28'h6000000, 28'h4000000, 1'b0);
        finish_req("ne_1p5_div_1", 28'h6000000, 1'b0, 29, 9, 1'b1);

        send(28'h4000000, 28'h6000000, 1'b1);
        finish_req("z_1_div_1p5", 28'h2AAA800, 1'b0, 29, 9, 1'b1);
        lhs = 56'(q) * 56'(28'h6000000);
        rhs = 56'(28'h4000000) << 26;
        check("z_1_div_1p5_not_above", 64'(lhs <= rhs), 64'd1);

        send(28'h4000000, 28'h6000000, 1'b0);
        finish_req("ne_1_div_1p5", 28'h2AAA800, 1'b0, 29, 9, 1'b1);

        send(28'h6000000, 28'h0000000, 1'b0);
        finish_req("div_zero", 28'hFFFFFF0, 1'b1, 1, 0, 1'b1);

        send(28'h4000000, 28'h6000000, 1'b1);
        finish_req("hold_req", 28'h2AAA800, 1'b0, 29, 9, 1'b0);
        held_q = q;
        bad = 0;
        a = 28'h6000000; bv = 28'h4000000; mode = 1'b0; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (q !== held_q || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_in_ready",  64'(in_ready),  64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        send(28'h6000000, 28'h4000000, 1'b0);
        finish_req("after_hold", 28'h6000000, 1'b0, 29, 9, 1'b1);

        send(28'h4000000, 28'h6000000, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        send(28'h4000000, 28'h6000000, 1'b1);
        finish_req("post_reset", 28'h2AAA800, 1'b0, 29, 9, 1'b1);

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 150; i++) begin
                ra = {2'b01, 26'($urandom)};
                rb = {2'b01, 26'($urandom)};
                send(ra, rb, m[0]);
                finish_req(m == 0 ? "rand_ne" : "rand_z", model_q(ra, rb, m[0]), 1'b0, 29, 9, 1'b1);
                if (m == 1) begin
                    lhs = 56'(q) * 56'(rb);
                    rhs = 56'(ra) << 26;
                    check("rand_z_not_above", 64'(lhs <= rhs), 64'd1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
